mine_field_gen: RTL and testbench

- Builds the hidden minefield that game_controller reads. At game start it places NUM_MINES mines in a ROWS x COLS grid using a free-running LFSR, and it never puts a mine on the player's safe cell.
- It then computes the neighbour count for every cell and exposes the result on a registered read port.
- It sits directly upstream of game_controller. It is triggered by the same start switch the top-level screen FSM uses.

---
 rtl/mine_pkg.sv | 28 ++
 rtl/mine_lfsr.sv | 30 +++
 rtl/mine_field_gen.sv | 213 +++++++++++++++++++++
 tb/tb_mine_field_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mine_pkg.sv
// mine_pkg: definitions shared by mine_field_gen and game_controller.
//   - Cell encoding of the minefield read port (0-8 neighbour count, 9 mine).
//   - Generator FSM state encoding.
//   - Galois LFSR tap constant and one-step helper.
package mine_pkg;

    // A cell value of CELL_MINE marks a mine.
    // Any other cell holds its neighbour count, 0..CELL_MAX_COUNT.
    localparam logic [3:0] CELL_MINE      = 4'd9;
    localparam logic [3:0] CELL_MAX_COUNT = 4'd8;

    // Taps for the 16-bit right-shifting Galois LFSR (maximal length).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PLACE = 3'd2,
        COUNT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Advance the Galois LFSR by one step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
// mine_lfsr: free-running 16-bit Galois LFSR used to pick mine candidates.
// It steps on every clock, so the generated field depends on when start arrives.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset; reloads SEED
//   value  out  low OUT_W bits of the LFSR state (the candidate cell address)
module mine_lfsr
    import mine_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign value = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/mine_field_gen.sv
// mine_field_gen: builds the hidden minefield for game_controller.
// On a rising edge of start it does the following:
//   1. Clears the field.
//   2. Places NUM_MINES mines at LFSR-chosen cells. The latched safe cell is never used.
//   3. Walks every cell and stores its value: 9 for a mine, otherwise its neighbour count.
// The field is then exposed on a registered read port.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   start      in   level switch; its rising edge starts generation (ignored while busy)
//   safe_addr  in   cell kept mine-free; sampled on the start edge
//   busy       out  generation in progress (CLEAR/PLACE/COUNT)
//   ready      out  field complete and valid (DONE)
//   rd_addr    in   row-major read address, row*COLS+col
//   rd_data    out  registered cell value, one-cycle latency; 0 for out-of-grid addresses
module mine_field_gen
    import mine_pkg::*;
#(
    parameter int          ROWS      = 8,
    parameter int          COLS      = 8,
    parameter int          NUM_MINES = 10,
    parameter int          ADDR_W    = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] safe_addr,
    output logic              busy,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_data
);

    localparam int                CELLS     = ROWS * COLS;
    localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] MINES_M1  = ADDR_W'(NUM_MINES - 1);

    state_t            state_reg, state_next;
    logic              start_q_reg;
    logic [ADDR_W-1:0] safe_reg;
    logic [ADDR_W-1:0] placed_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              busy_reg, ready_reg;
    logic [3:0]        rd_data_reg;

    logic              mine_reg [CELLS];
    logic [3:0]        cnt_reg  [CELLS];

    logic [ADDR_W-1:0] cand;
    logic              start_edge;
    logic              cand_ok;
    logic              place_accept;
    logic              idle_like;

    // Neighbour summation working variables.
    int                nbr_row, nbr_col, nbr_r, nbr_c;
    logic [ADDR_W-1:0] nbr_idx;
    logic [3:0]        nbr_sum;
    logic [3:0]        cell_val;

    mine_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (ADDR_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (cand)
    );

    assign start_edge = start & ~start_q_reg;
    assign idle_like  = (state_reg == IDLE) || (state_reg == DONE);

    // Candidates beyond the grid are rejected first.
    // This keeps the mine_reg lookup in range when 2^ADDR_W > CELLS.
    assign cand_ok      = ({1'b0, cand} < CELLS_EXT) && !mine_reg[cand] && (cand != safe_reg);
    assign place_accept = (state_reg == PLACE) && cand_ok;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = PLACE;
            end
            PLACE: begin
                if (cand_ok && (placed_reg == MINES_M1)) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- control datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q_reg <= 1'b0;
            safe_reg    <= '0;
            placed_reg  <= '0;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            start_q_reg <= start;
            if (idle_like && start_edge) begin
                safe_reg <= safe_addr;
            end
            if (state_reg == CLEAR) begin
                placed_reg <= '0;
                idx_reg    <= '0;
            end else begin
                if (place_accept) begin
                    placed_reg <= placed_reg + 1'b1;
                end
                if (state_reg == COUNT) begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
            // Registered from the next state.
            // The flags therefore line up with the state they describe.
            busy_reg  <= (state_next == CLEAR) || (state_next == PLACE) || (state_next == COUNT);
            ready_reg <= (state_next == DONE);
        end
    end

    // ---------------- neighbour count for cell idx ----------------
    // A neighbour contributes only if its row and column both lie inside the grid.
    // There is no wrap at the grid edges.
    always_comb begin
        nbr_row = int'(idx_reg) / COLS;
        nbr_col = int'(idx_reg) % COLS;
        nbr_r   = 0;
        nbr_c   = 0;
        nbr_idx = '0;
        nbr_sum = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nbr_r = nbr_row + dr;
                nbr_c = nbr_col + dc;
                if (!((dr == 0) && (dc == 0)) &&
                    (nbr_r >= 0) && (nbr_r < ROWS) &&
                    (nbr_c >= 0) && (nbr_c < COLS)) begin
                    nbr_idx = ADDR_W'(nbr_r * COLS + nbr_c);
                    nbr_sum = nbr_sum + {3'b000, mine_reg[nbr_idx]};
                end
            end
        end
        cell_val = mine_reg[idx_reg] ? CELL_MINE : nbr_sum;
    end

    // ---------------- per-cell storage ----------------
    // Each cell owns its mine bit and count register.
    // This gives one-cycle clear in CLEAR and a full wipe on reset.
    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mine_reg[gi] <= 1'b0;
                    cnt_reg[gi]  <= 4'd0;
                end else if (state_reg == CLEAR) begin
                    mine_reg[gi] <= 1'b0;
                    cnt_reg[gi]  <= 4'd0;
                end else begin
                    if (place_accept && (cand == ADDR_W'(gi))) begin
                        mine_reg[gi] <= 1'b1;
                    end
                    if ((state_reg == COUNT) && (idx_reg == ADDR_W'(gi))) begin
                        cnt_reg[gi] <= cell_val;
                    end
                end
            end
        end
    endgenerate

    // ---------------- registered read port ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg <= 4'd0;
        end else if ({1'b0, rd_addr} < CELLS_EXT) begin
            rd_data_reg <= cnt_reg[rd_addr];
        end else begin
            rd_data_reg <= 4'd0;
        end
    end

    assign busy    = busy_reg;
    assign ready   = ready_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_mine_field_gen.sv
// Testbench for mine_field_gen (8x8 grid, 10 mines, default seed).
// A reference LFSR tracks the DUT's LFSR from reset.
// Each start edge does two things:
//   - predicts the exact mine placement and every cell value;
//   - pushes the 64 predicted values to a scoreboard queue.
// The queue is popped as the field is read back.
module tb_mine_field_gen;

    localparam int          ROWS      = 8;
    localparam int          COLS      = 8;
    localparam int          CELLS     = 64;
    localparam int          NUM_MINES = 10;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] safe_addr = '0;
    logic [5:0] rd_addr = '0;
    logic       busy, ready;
    logic [3:0] rd_data;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];

    logic [15:0] mdl_lfsr;
    logic [3:0]  rb [CELLS];
    bit          first_map [CELLS];

    always #10 clk = ~clk;

    mine_field_gen #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .NUM_MINES (NUM_MINES),
        .ADDR_W    (6),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .safe_addr (safe_addr),
        .busy      (busy),
        .ready     (ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR: reloads on reset, steps on every clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) mdl_lfsr <= SEED;
        else      mdl_lfsr <= lstep(mdl_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called on the negedge where start is raised.
    // The first candidate is examined two clocks after the edge-detect clock.
    // It is therefore two LFSR steps ahead of the current state.
    task automatic model_push(input logic [5:0] safe, output int p);
        logic [15:0] v;
        bit          mine [CELLS];
        int          placed, cand, n, rej_safe, rej_dup;
        v = lstep(lstep(mdl_lfsr));
        placed = 0; p = 0; rej_safe = 0; rej_dup = 0;
        for (int i = 0; i < CELLS; i++) mine[i] = 0;
        while (placed < NUM_MINES) begin
            cand = int'(v[5:0]);
            p++;
            if (cand == int'(safe))  rej_safe++;
            else if (mine[cand])     rej_dup++;
            else begin
                mine[cand] = 1;
                placed++;
            end
            v = lstep(v);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mine[r*COLS+c]) begin
                    exp_q.push_back(9);
                end else begin
                    n = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < ROWS && c+dc >= 0 && c+dc < COLS)
                                n += int'(mine[(r+dr)*COLS + (c+dc)]);
                    exp_q.push_back(n);
                end
            end
        end
        $display("start: safe=%0d candidates=%0d safe_rejects=%0d dup_rejects=%0d", safe, p, rej_safe, rej_dup);
    endtask

    task automatic run_gen(input logic [5:0] safe, input bit toggle_in_count);
        int p, n;
        bit seen;
        safe_addr = safe;
        model_push(safe, p);
        start = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_after_edge", busy, 1);
                check("ready_low_after_edge", ready, 0);
            end
            // Well inside COUNT: release start and raise it again.
            // That rising edge must be ignored.
            if (toggle_in_count && n == p + 10) start = 1'b0;
            if (toggle_in_count && n == p + 20) start = 1'b1;
            if (ready) seen = 1;
        end
        check("ready_seen", seen, 1);
        check("latency_min", n >= p + 66, 1);
        check("latency_max", n <= p + 67, 1);
        check("busy_low_in_done", busy, 0);
        $display("gen done: cycles=%0d candidates=%0d", n, p);
        start = 1'b0;
    endtask

    task automatic read_field(input bit use_sb, input string tag);
        logic [31:0] e;
        for (int a = 0; a < CELLS; a++) begin
            rd_addr = 6'(a);
            @(negedge clk);
            rb[a] = rd_data;
            if (use_sb) begin
                e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                check(tag, rd_data, e);
            end else begin
                check(tag, rd_data, 0);
            end
        end
        $display("readback %s: 64 cells", tag);
    endtask

    // Consistency checks computed only from the read-back field.
    task automatic check_field(input logic [5:0] safe);
        int mines, maxv, mism, n;
        mines = 0; maxv = 0; mism = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (rb[i] == 4'd9) begin
                mines++;
            end else begin
                if (int'(rb[i]) > maxv) maxv = int'(rb[i]);
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && i/COLS+dr >= 0 && i/COLS+dr < ROWS &&
                            i%COLS+dc >= 0 && i%COLS+dc < COLS)
                            n += int'(rb[(i/COLS+dr)*COLS + i%COLS+dc] == 4'd9);
                if (n != int'(rb[i])) mism++;
            end
        end
        check("mine_total", mines, NUM_MINES);
        check("safe_not_mine", rb[safe] == 4'd9, 0);
        check("corner0_le3", (rb[0] == 4'd9) || (rb[0] <= 4'd3), 1);
        check("edge3_le5", (rb[3] == 4'd9) || (rb[3] <= 4'd5), 1);
        check("nonmine_le8", maxv <= 8, 1);
        check("recount_mismatches", mism, 0);
    endtask

    initial begin
        logic [15:0] v;
        logic [5:0]  safe2;
        int          diff;

        // Reset, then a long idle period.
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", ready, 0);
        read_field(0, "idle_cell");

        // Nominal generation with safe cell 27; a start toggle during COUNT is ignored.
        run_gen(6'd27, 1'b1);
        read_field(1, "gen1_cell");
        check_field(6'd27);
        for (int i = 0; i < CELLS; i++) first_map[i] = (rb[i] == 4'd9);

        // Restart from DONE.
        // The safe cell is chosen as the very first candidate, so the DUT must reject it.
        check("ready_before_restart", ready, 1);
        v = lstep(lstep(mdl_lfsr));
        safe2 = v[5:0];
        run_gen(safe2, 1'b0);
        read_field(1, "gen2_cell");
        check_field(safe2);
        diff = 0;
        for (int i = 0; i < CELLS; i++) if (first_map[i] != (rb[i] == 4'd9)) diff++;
        check("field_differs", diff != 0, 1);

        // Reset in the middle of PLACE.
        safe_addr = 6'd5;
        start = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_in_place", busy, 1);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_rd_data", rd_data, 0);
        rst = 1'b1;
        @(negedge clk);
        read_field(0, "post_rst_cell");

        // A normal generation after the interrupted one.
        run_gen(6'd40, 1'b0);
        read_field(1, "gen3_cell");
        check_field(6'd40);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
